// File: rtl/frame_sequencer_if.sv
// frame_sequencer bus bundle
// GPU register port plus read-only memory port
interface frame_sequencer_if;
  logic [7:0]  g_address;
  logic        g_write;
  logic [31:0] g_writedata;
  logic        g_read;
  logic [31:0] g_readdata;
  logic        g_waitrequest;
  logic        gpu_irq;
  logic [31:0] m_address;
  logic        m_read;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        m_waitrequest;

  modport master (
    output g_address, g_write, g_writedata, g_read,
    input  g_readdata, g_waitrequest, gpu_irq,
    output m_address, m_read,
    input  m_readdata, m_readdatavalid, m_waitrequest
  );

  modport slave (
    input  g_address, g_write, g_writedata, g_read,
    output g_readdata, g_waitrequest, gpu_irq,
    input  m_address, m_read,
    output m_readdata, m_readdatavalid, m_waitrequest
  );
endinterface

// File: rtl/frame_sequencer.sv
// frame_sequencer: autonomous voxel_gpu frame driver
// camera load, per-batch voxel/palette/pixel commands, irq ack
module frame_sequencer #(
  parameter int          H_RESOLUTION   = 320,
  parameter int          V_RESOLUTION   = 240,
  parameter int          NUM_SHADERS    = 320,
  parameter logic [31:0] FB_BASE        = 32'hC800_0000,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] cfg_cam_base,
  input  logic [31:0] cfg_voxel_base,
  input  logic [15:0] cfg_voxel_count,
  input  logic [31:0] cfg_palette_base,
  input  logic [15:0] cfg_palette_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  frame_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, CAM_RD, CAM_WR, BATCH,
    VOX_RD, VOX_WR, PAL_RD, PAL_WR,
    PIX_WR, WAIT_IRQ, ACK, RECOVER, DONE
  } state_t;

  localparam int COL_BITS = $clog2(H_RESOLUTION);
  localparam int ROW_BITS = $clog2(V_RESOLUTION);
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] TOTAL =
    32'(H_RESOLUTION * V_RESOLUTION);
  localparam logic [31:0] NS = 32'(NUM_SHADERS);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [COL_BITS-1:0] COL_LAST =
    COL_BITS'(H_RESOLUTION - 1);

  state_t state, state_n, ret;
  state_t after_batch, after_vox, after_pix;

  logic [31:0] cam_base, vox_base, pal_base;
  logic [15:0] vox_cnt, pal_cnt;
  logic [15:0] vox_idx, pal_idx;
  logic [3:0]  cam_idx;
  logic [31:0] pix, batch_start, batch_end, sum;
  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic [TW-1:0] timer;
  logic [31:0] word;
  logic [31:0] pix_addr;
  logic m_acc, m_hit, g_acc, m_take;
  logic vox_more, pal_more, pix_more, frame_end;

  assign g_acc  = (bus.g_write | bus.g_read)
                & ~bus.g_waitrequest;
  assign m_take = bus.m_read & ~bus.m_waitrequest;
  assign m_hit  = m_acc & bus.m_readdatavalid;

  assign sum       = batch_start + NS;
  assign batch_end = (sum > TOTAL) ? TOTAL : sum;
  assign frame_end = sum >= TOTAL;
  assign pix_more  = (pix + 32'd1) < batch_end;
  assign vox_more  = ({1'b0, vox_idx} + 17'd1)
                   < {1'b0, vox_cnt};
  assign pal_more  = ({1'b0, pal_idx} + 17'd1)
                   < {1'b0, pal_cnt};
  assign pix_addr  = FB_BASE
                   | (32'(row) << (COL_BITS + 1))
                   | (32'(col) << 1);

  // step that follows each acknowledged command
  always_comb begin
    after_batch = PIX_WR;
    after_vox   = PIX_WR;
    after_pix   = BATCH;
    if (vox_cnt != 16'd0) after_batch = VOX_RD;
    else if (pal_cnt != 16'd0) after_batch = PAL_RD;
    if (vox_more) after_vox = VOX_RD;
    else if (pal_cnt != 16'd0) after_vox = PAL_RD;
    if (pix_more) after_pix = PIX_WR;
    else if (frame_end) after_pix = DONE;
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (start) state_n = CAM_RD;
      CAM_RD:
        if (m_hit) state_n = CAM_WR;
      CAM_WR:
        if (g_acc)
          state_n = (cam_idx == 4'd14) ? BATCH : CAM_RD;
      VOX_RD:
        if (m_hit) state_n = VOX_WR;
      PAL_RD:
        if (m_hit) state_n = PAL_WR;
      BATCH, VOX_WR, PAL_WR, PIX_WR:
        if (g_acc) state_n = WAIT_IRQ;
      WAIT_IRQ:
        if (bus.gpu_irq || timer == T_LAST)
          state_n = ACK;
      ACK:
        if (g_acc) begin
          if (bus.g_readdata == 32'd0)
            state_n = ret;
          else if (bus.g_readdata == 32'd1)
            state_n = WAIT_IRQ;
          else
            state_n = RECOVER;
        end
      RECOVER:
        if (g_acc) state_n = IDLE;
      DONE:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // bus drive and done pulse from current state
  always_comb begin
    bus.g_address   = 8'h00;
    bus.g_write     = 1'b0;
    bus.g_writedata = 32'd0;
    bus.g_read      = 1'b0;
    bus.m_address   = 32'd0;
    bus.m_read      = 1'b0;
    done            = 1'b0;
    unique case (state)
      CAM_RD: begin
        bus.m_read    = ~m_acc;
        bus.m_address = cam_base
                      + {26'd0, cam_idx, 2'b00};
      end
      CAM_WR: begin
        bus.g_write     = 1'b1;
        bus.g_address   = 8'h10 + {4'h0, cam_idx};
        bus.g_writedata = word;
      end
      BATCH: begin
        bus.g_write     = 1'b1;
        bus.g_address   = 8'h03;
        bus.g_writedata = batch_start;
      end
      VOX_RD: begin
        bus.m_read    = ~m_acc;
        bus.m_address = vox_base
                      + {14'd0, vox_idx, 2'b00};
      end
      VOX_WR: begin
        bus.g_write     = 1'b1;
        bus.g_address   = 8'h00;
        bus.g_writedata = word;
      end
      PAL_RD: begin
        bus.m_read    = ~m_acc;
        bus.m_address = pal_base
                      + {14'd0, pal_idx, 2'b00};
      end
      PAL_WR: begin
        bus.g_write     = 1'b1;
        bus.g_address   = 8'h01;
        bus.g_writedata = word;
      end
      PIX_WR: begin
        bus.g_write     = 1'b1;
        bus.g_address   = 8'h02;
        bus.g_writedata = pix_addr;
      end
      ACK: begin
        bus.g_read    = 1'b1;
        bus.g_address = 8'h0f;
      end
      RECOVER: begin
        bus.g_write     = 1'b1;
        bus.g_address   = 8'h0f;
        bus.g_writedata = 32'd1;
      end
      DONE:
        done = 1'b1;
      default: ;
    endcase
  end

  // counters, latched cfg and fetched word
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cam_base    <= '0;
      vox_base    <= '0;
      pal_base    <= '0;
      vox_cnt     <= '0;
      pal_cnt     <= '0;
      vox_idx     <= '0;
      pal_idx     <= '0;
      cam_idx     <= '0;
      pix         <= '0;
      batch_start <= '0;
      row         <= '0;
      col         <= '0;
      timer       <= '0;
      word        <= '0;
      m_acc       <= 1'b0;
      ret         <= IDLE;
    end else begin
      if (state == IDLE && start) begin
        cam_base    <= cfg_cam_base;
        vox_base    <= cfg_voxel_base;
        pal_base    <= cfg_palette_base;
        vox_cnt     <= cfg_voxel_count;
        pal_cnt     <= cfg_palette_count;
        cam_idx     <= '0;
        pix         <= '0;
        batch_start <= '0;
        row         <= '0;
        col         <= '0;
      end
      if (m_take)     m_acc <= 1'b1;
      else if (m_hit) m_acc <= 1'b0;
      if (m_hit) word <= bus.m_readdata;
      if (state == WAIT_IRQ) timer <= timer + TW'(1);
      else                   timer <= '0;
      if (g_acc) begin
        unique case (state)
          CAM_WR:
            cam_idx <= cam_idx + 4'd1;
          BATCH: begin
            vox_idx <= '0;
            pal_idx <= '0;
            ret     <= after_batch;
          end
          VOX_WR: begin
            vox_idx <= vox_idx + 16'd1;
            ret     <= after_vox;
          end
          PAL_WR: begin
            pal_idx <= pal_idx + 16'd1;
            ret     <= pal_more ? PAL_RD : PIX_WR;
          end
          PIX_WR: begin
            pix <= pix + 32'd1;
            ret <= after_pix;
            if (!pix_more) batch_start <= sum;
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + ROW_BITS'(1);
            end else begin
              col <= col + COL_BITS'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // busy follows the frame; error is sticky until next start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy  <= 1'b0;
      error <= 1'b0;
    end else begin
      busy <= !(state_n == IDLE || state_n == DONE);
      if (state == IDLE && start)
        error <= 1'b0;
      else if (state == RECOVER && g_acc)
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: scoreboard bench with GPU and memory stubs
// small frame geometry keeps full frames short
module tb_frame_sequencer;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int NS = 6;
  localparam int TO = 16;
  localparam logic [31:0] FB = 32'hC800_0000;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_cam_base = '0;
  logic [31:0] cfg_voxel_base = '0;
  logic [15:0] cfg_voxel_count = '0;
  logic [31:0] cfg_palette_base = '0;
  logic [15:0] cfg_palette_count = '0;
  logic        busy, done, error;

  frame_sequencer_if bus();

  frame_sequencer #(
    .H_RESOLUTION(H),
    .V_RESOLUTION(V),
    .NUM_SHADERS(NS),
    .FB_BASE(FB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .cfg_cam_base(cfg_cam_base),
    .cfg_voxel_base(cfg_voxel_base),
    .cfg_voxel_count(cfg_voxel_count),
    .cfg_palette_base(cfg_palette_base),
    .cfg_palette_count(cfg_palette_count),
    .busy(busy),
    .done(done),
    .error(error),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];
  logic [31:0] pix_log[$];
  logic [31:0] bat_log[$];
  int vp_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  logic stall = 1'b0;
  logic err_mode = 1'b0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] a,
                      input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_cam(input logic [31:0] cb);
    for (int k = 0; k < 15; k++)
      push(8'h10 + 8'(k), mem_word(cb + 32'(4 * k)));
  endtask

  task automatic push_frame(input logic [31:0] cb,
                            input logic [31:0] vb,
                            input logic [31:0] pb,
                            input int vc, input int pc);
    push_cam(cb);
    for (int bs = 0; bs < H * V; bs += NS) begin
      push(8'h03, 32'(bs));
      for (int v = 0; v < vc; v++)
        push(8'h00, mem_word(vb + 32'(4 * v)));
      for (int p = 0; p < pc; p++)
        push(8'h01, mem_word(pb + 32'(4 * p)));
      for (int n = bs; n < bs + NS && n < H * V; n++)
        push(8'h02, FB | 32'((n / H) << 4)
                       | 32'((n % H) << 1));
    end
  endtask

  task automatic set_cfg(input logic [31:0] cb,
                         input logic [31:0] vb,
                         input logic [31:0] pb,
                         input int vc, input int pc);
    cfg_cam_base      = cb;
    cfg_voxel_base    = vb;
    cfg_palette_base  = pb;
    cfg_voxel_count   = 16'(vc);
    cfg_palette_count = 16'(pc);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_end(input string name,
                          input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy %0d after %0d cycles",
               name, busy, limit);
    end
  endtask

  // GPU register stub: irq 3 cycles after each command
  logic        g_wacc, g_racc;
  logic [7:0]  g_wa;
  int          irq_cnt, g_hold, vox_seen;
  logic [31:0] status;
  initial begin
    bus.gpu_irq       = 1'b0;
    bus.g_waitrequest = 1'b0;
    bus.g_readdata    = '0;
    irq_cnt  = 0;
    g_hold   = 0;
    vox_seen = 0;
    status   = '0;
    forever begin
      @(negedge clock);
      g_wacc = bus.g_write && !bus.g_waitrequest;
      g_racc = bus.g_read && !bus.g_waitrequest;
      g_wa   = bus.g_address;
      @(posedge clock);
      #1;
      if (!reset_n || start) begin
        bus.gpu_irq = 1'b0;
        irq_cnt  = 0;
        vox_seen = 0;
        status   = '0;
      end else begin
        if (g_racc) bus.gpu_irq = 1'b0;
        if (g_wacc && g_wa < 8'h04) begin
          if (g_wa == 8'h00) vox_seen++;
          if (err_mode && g_wa == 8'h00 && vox_seen == 2)
            status = 32'd2;
          else
            irq_cnt = 3;
        end else if (irq_cnt != 0) begin
          irq_cnt--;
          if (irq_cnt == 0) bus.gpu_irq = 1'b1;
        end
      end
      bus.g_readdata = status;
      if (g_hold > 0) begin
        bus.g_waitrequest = 1'b1;
        g_hold--;
      end else if (stall && $urandom_range(0, 2) == 0) begin
        bus.g_waitrequest = 1'b1;
        g_hold = $urandom_range(0, 4);
      end else begin
        bus.g_waitrequest = 1'b0;
      end
    end
  end

  // memory stub: data valid the cycle after acceptance
  logic        m_acc_s;
  logic [31:0] m_addr_s;
  int          m_hold;
  initial begin
    bus.m_waitrequest   = 1'b0;
    bus.m_readdatavalid = 1'b0;
    bus.m_readdata      = '0;
    m_hold = 0;
    forever begin
      @(negedge clock);
      m_acc_s  = bus.m_read && !bus.m_waitrequest;
      m_addr_s = bus.m_address;
      @(posedge clock);
      #1;
      bus.m_readdatavalid = reset_n && m_acc_s;
      bus.m_readdata = m_acc_s ? mem_word(m_addr_s) : '0;
      if (m_hold > 0) begin
        bus.m_waitrequest = 1'b1;
        m_hold--;
      end else if (stall && $urandom_range(0, 2) == 0) begin
        bus.m_waitrequest = 1'b1;
        m_hold = $urandom_range(0, 4);
      end else begin
        bus.m_waitrequest = 1'b0;
      end
    end
  end

  // monitor: scoreboard pops, stall stability, logs
  wr_t         got, e;
  logic        g_st, m_st;
  logic [41:0] g_snap;
  logic [32:0] m_snap;
  initial begin
    g_st = 1'b0;
    m_st = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        g_st = 1'b0;
        m_st = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (g_st)
          chk("g_hold_stable",
              64'({bus.g_address, bus.g_write,
                   bus.g_read, bus.g_writedata}),
              64'(g_snap));
        if (m_st)
          chk("m_hold_stable",
              64'({bus.m_read, bus.m_address}),
              64'(m_snap));
        g_st = (bus.g_write || bus.g_read)
             && bus.g_waitrequest;
        g_snap = {bus.g_address, bus.g_write,
                  bus.g_read, bus.g_writedata};
        m_st = bus.m_read && bus.m_waitrequest;
        m_snap = {bus.m_read, bus.m_address};
        if (bus.g_write || bus.g_read)
          chk("g_rw_exclusive",
              64'(bus.g_write & bus.g_read), 64'd0);
        if (bus.g_read && !bus.g_waitrequest) begin
          rd_cnt++;
          chk("ack_addr", 64'(bus.g_address), 64'h0f);
        end
        if (bus.g_write && !bus.g_waitrequest) begin
          got.a = bus.g_address;
          got.d = bus.g_writedata;
          if (got.a == 8'h02) pix_log.push_back(got.d);
          if (got.a == 8'h03) bat_log.push_back(got.d);
          if (got.a == 8'h00 || got.a == 8'h01) vp_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %h:%h want none",
                     got.a, got.d);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(got.a), 64'(e.a));
            chk("wr_data", 64'(got.d), 64'(e.d));
          end
        end
      end
    end
  end

  // directed sequence
  int pb0, bb0, vp0, dn0, rd0, n;
  initial begin
    repeat (3) @(negedge clock);
    chk("rst_ctrl",
        64'({busy, done, error, bus.g_write,
             bus.g_read, bus.m_read}), 64'd0);
    chk("rst_g_address", 64'(bus.g_address), 64'd0);
    chk("rst_m_address", 64'(bus.m_address), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // A: one voxel, one palette, rogue start mid-frame
    set_cfg(32'h1000, 32'h2000, 32'h3000, 1, 1);
    push_frame(32'h1000, 32'h2000, 32'h3000, 1, 1);
    pb0 = pix_log.size();
    bb0 = bat_log.size();
    dn0 = done_cnt;
    pulse_start();
    chk("A_error_low", 64'(error), 64'd0);
    repeat (40) @(negedge clock);
    set_cfg(32'h9000, 32'h9100, 32'h9200, 7, 7);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_end("A", 20000);
    @(negedge clock);
    chk("A_done_once", 64'(done_cnt - dn0), 64'd1);
    chk("A_error", 64'(error), 64'd0);
    chk("A_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("A_pix_count", 64'(pix_log.size() - pb0), 64'd32);
    chk("A_pix0", 64'(pix_log[pb0 + 0]), 64'hC800_0000);
    chk("A_pix1", 64'(pix_log[pb0 + 1]), 64'hC800_0002);
    chk("A_pix5", 64'(pix_log[pb0 + 5]), 64'hC800_000A);
    chk("A_pix6", 64'(pix_log[pb0 + 6]), 64'hC800_000C);
    chk("A_pix8", 64'(pix_log[pb0 + 8]), 64'hC800_0010);
    chk("A_pix31", 64'(pix_log[pb0 + 31]), 64'hC800_003E);
    chk("A_batches", 64'(bat_log.size() - bb0), 64'd6);
    chk("A_batch1", 64'(bat_log[bb0 + 1]), 64'd6);
    chk("A_batch5", 64'(bat_log[bb0 + 5]), 64'd30);

    // B: empty voxel/palette lists under random stalls
    stall = 1'b1;
    set_cfg(32'h1400, 32'h2400, 32'h3400, 0, 0);
    push_frame(32'h1400, 32'h2400, 32'h3400, 0, 0);
    vp0 = vp_cnt;
    dn0 = done_cnt;
    pulse_start();
    wait_end("B", 20000);
    @(negedge clock);
    chk("B_done_once", 64'(done_cnt - dn0), 64'd1);
    chk("B_no_vox_pal", 64'(vp_cnt - vp0), 64'd0);
    chk("B_queue_empty", 64'(exp_q.size()), 64'd0);

    // C: GPU error after second voxel command
    stall = 1'b0;
    err_mode = 1'b1;
    set_cfg(32'h1800, 32'h2800, 32'h3800, 3, 1);
    push_cam(32'h1800);
    push(8'h03, 32'd0);
    push(8'h00, mem_word(32'h2800));
    push(8'h00, mem_word(32'h2804));
    push(8'h0f, 32'd1);
    dn0 = done_cnt;
    rd0 = rd_cnt;
    pulse_start();
    wait_end("C", 5000);
    @(negedge clock);
    chk("C_error", 64'(error), 64'd1);
    chk("C_busy", 64'(busy), 64'd0);
    chk("C_no_done", 64'(done_cnt - dn0), 64'd0);
    chk("C_ack_reads", 64'(rd_cnt - rd0), 64'd3);
    chk("C_queue_empty", 64'(exp_q.size()), 64'd0);
    err_mode = 1'b0;

    // E: reset while the first voxel read is pending
    set_cfg(32'h1C00, 32'h2C00, 32'h3C00, 2, 1);
    push_frame(32'h1C00, 32'h2C00, 32'h3C00, 2, 1);
    pulse_start();
    chk("E_error_cleared", 64'(error), 64'd0);
    n = 0;
    while (!(bus.m_read && bus.m_address == 32'h2C00)
           && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("E_reached_vox_rd",
        64'(bus.m_read && bus.m_address == 32'h2C00), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("E_rst_ctrl",
        64'({busy, done, error, bus.g_write,
             bus.g_read, bus.m_read}), 64'd0);
    chk("E_rst_m_address", 64'(bus.m_address), 64'd0);
    chk("E_rst_g_data", 64'(bus.g_writedata), 64'd0);
    @(negedge clock);
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // D: full frame after reset, stalls on
    stall = 1'b1;
    set_cfg(32'h1000, 32'h2000, 32'h3000, 2, 2);
    push_frame(32'h1000, 32'h2000, 32'h3000, 2, 2);
    pb0 = pix_log.size();
    dn0 = done_cnt;
    pulse_start();
    wait_end("D", 20000);
    @(negedge clock);
    chk("D_done_once", 64'(done_cnt - dn0), 64'd1);
    chk("D_error", 64'(error), 64'd0);
    chk("D_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("D_pix_count", 64'(pix_log.size() - pb0), 64'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
